sv_bus_arbiter: RTL and testbench

- Owns the shared 16-bit system bus (WRAM/VRAM/ROM/registers).
- Shares it between three requesters: CPU (default owner), video DMA (VRAM/WRAM copy engine) and audio DMA (sample fetch).
- Drives the muxed bus address, data and write strobe and the CPU RDY line. Replaces the ad-hoc dma_busy muxing in the top level.
- Guarantees bus handover never interrupts a CPU write. Bounds DMA bursts so the CPU is not starved.

---
 rtl/sv_pkg.sv | 14 +
 rtl/sv_arb_pick.sv | 34 +++
 rtl/sv_bus_arbiter.sv | 147 ++++++++++++++
 tb/tb_sv_bus_arbiter.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/sv_pkg.sv
// Shared types and bus-width constants for the system-bus arbiter slice.
// No logic, no latency, no flow control.
// Owner encoding is visible on the arbiter's owner port.
package sv_pkg;
  localparam int AW = 16;
  localparam int DW = 8;

  typedef enum logic [1:0] {
    OWN_CPU   = 2'd0,
    OWN_VDMA  = 2'd1,
    OWN_ADMA  = 2'd2,
    OWN_GUARD = 2'd3
  } owner_t;
endpackage

// File: rtl/sv_arb_pick.sv
// Next-owner select from DMA requests, cpu_we and (SV_ARB_RR_EN) last_dma.
// Purely combinational, zero latency.
// A CPU write in progress forces OWN_CPU so the write is never cut short.
module sv_arb_pick
  import sv_pkg::*;
(
  input  logic   cpu_we,
  input  logic   vdma_req,
  input  logic   adma_req,
`ifdef SV_ARB_RR_EN
  input  logic   last_dma,
`endif
  output owner_t next_owner
);

  owner_t tie_owner;

`ifdef SV_ARB_RR_EN
  // last_dma: 0 = video served last, 1 = audio served last
  assign tie_owner = last_dma ? OWN_VDMA : OWN_ADMA;
`else
  assign tie_owner = OWN_ADMA;
`endif

  always_comb begin
    next_owner = OWN_CPU;
    if (!cpu_we) begin
      if (adma_req && vdma_req) next_owner = tie_owner;
      else if (adma_req)        next_owner = OWN_ADMA;
      else if (vdma_req)        next_owner = OWN_VDMA;
    end
  end

endmodule

// File: rtl/sv_bus_arbiter.sv
// System-bus owner arbiter (CPU / video DMA / audio DMA); optional SV_ARB_RR_EN round-robin.
// Grants change one bus_ce edge after a request; bus mux is combinational from owner.
// DMA bursts capped at MAX_BURST counted cycles, then GUARD_CYCLES CPU-owned slot.
module sv_bus_arbiter
  import sv_pkg::*;
#(
  parameter int MAX_BURST    = 16,
  parameter int GUARD_CYCLES = 2
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          bus_ce,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_dout,
  input  logic          cpu_we,
  output logic          cpu_rdy,
  input  logic          vdma_req,
  input  logic [AW-1:0] vdma_addr,
  input  logic [DW-1:0] vdma_dout,
  input  logic          vdma_we,
  output logic          vdma_gnt,
  input  logic          lcd_busy,
  input  logic          adma_req,
  input  logic [AW-1:0] adma_addr,
  output logic          adma_gnt,
  output logic [AW-1:0] bus_addr,
  output logic [DW-1:0] bus_dout,
  output logic          bus_we,
  output logic [1:0]    owner
);

  localparam int BW = $clog2(MAX_BURST + 1);
  localparam int GW = $clog2(GUARD_CYCLES + 1);

  owner_t        owner_q, owner_d, pick_owner;
  logic [BW-1:0] burst_cnt, burst_d;
  logic [GW-1:0] guard_cnt, guard_d;
  logic          pick_we, own_req, vdma_stall;

  // While a DMA owns the bus the CPU is halted, so its write strobe is irrelevant
  assign pick_we    = (owner_q == OWN_CPU || owner_q == OWN_GUARD) ? cpu_we : 1'b0;
  assign own_req    = (owner_q == OWN_VDMA) ? vdma_req : adma_req;
  assign vdma_stall = (owner_q == OWN_VDMA) && lcd_busy;

`ifdef SV_ARB_RR_EN
  logic last_dma;
  logic dma_end;

  assign dma_end = bus_ce && (owner_q == OWN_VDMA || owner_q == OWN_ADMA) && (owner_d != owner_q);

  always_ff @(posedge clk or posedge reset) begin
    if (reset)        last_dma <= 1'b0;
    else if (dma_end) last_dma <= (owner_q == OWN_ADMA);
  end

  sv_arb_pick u_pick (
    .cpu_we     (pick_we),
    .vdma_req   (vdma_req),
    .adma_req   (adma_req),
    .last_dma   (last_dma),
    .next_owner (pick_owner)
  );
`else
  sv_arb_pick u_pick (
    .cpu_we     (pick_we),
    .vdma_req   (vdma_req),
    .adma_req   (adma_req),
    .next_owner (pick_owner)
  );
`endif

  always_comb begin
    owner_d = owner_q;
    burst_d = burst_cnt;
    guard_d = guard_cnt;
    if (bus_ce) begin
      case (owner_q)
        OWN_CPU: begin
          owner_d = pick_owner;
          burst_d = '0;
        end
        OWN_VDMA, OWN_ADMA: begin
          if (!own_req) begin
            owner_d = pick_owner;
            burst_d = '0;
          end else if (!vdma_stall) begin
            // A stalled cycle neither counts nor can end the burst
            if (burst_cnt == BW'(MAX_BURST - 1)) begin
              owner_d = OWN_GUARD;
              burst_d = '0;
              guard_d = '0;
            end else begin
              burst_d = burst_cnt + BW'(1);
            end
          end
        end
        OWN_GUARD: begin
          if (guard_cnt == GW'(GUARD_CYCLES - 1)) begin
            owner_d = pick_owner;
            burst_d = '0;
            guard_d = '0;
          end else begin
            guard_d = guard_cnt + GW'(1);
          end
        end
        default: owner_d = OWN_CPU;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      owner_q   <= OWN_CPU;
      burst_cnt <= '0;
      guard_cnt <= '0;
    end else begin
      owner_q   <= owner_d;
      burst_cnt <= burst_d;
      guard_cnt <= guard_d;
    end
  end

  always_comb begin
    bus_addr = cpu_addr;
    bus_dout = cpu_dout;
    bus_we   = cpu_we;
    case (owner_q)
      OWN_VDMA: begin
        bus_addr = vdma_addr;
        bus_dout = vdma_dout;
        bus_we   = vdma_we & ~lcd_busy;
      end
      OWN_ADMA: begin
        bus_addr = adma_addr;
        bus_dout = '0;
        bus_we   = 1'b0;
      end
      default: ;
    endcase
  end

  assign cpu_rdy  = (owner_q == OWN_CPU) || (owner_q == OWN_GUARD);
  assign vdma_gnt = (owner_q == OWN_VDMA) & ~lcd_busy;
  assign adma_gnt = (owner_q == OWN_ADMA);
  assign owner    = owner_q;

endmodule

// File: tb/tb_sv_bus_arbiter.sv
// Bench for sv_bus_arbiter: directed vector table, burst/guard and reset sequences,
// then random traffic against a cycle-count reference model.
module tb_sv_bus_arbiter;
  import sv_pkg::*;

  localparam int MAXB = 16;
  localparam int GC   = 2;

  logic        clk = 1'b0, reset = 1'b1, bus_ce = 1'b0;
  logic [15:0] cpu_addr = 16'h1234, vdma_addr = 16'h8000, adma_addr = 16'hC000;
  logic [7:0]  cpu_dout = 8'hAA, vdma_dout = 8'h55;
  logic        cpu_we = 1'b0, vdma_req = 1'b0, vdma_we = 1'b1, lcd_busy = 1'b0, adma_req = 1'b0;
  logic        cpu_rdy, vdma_gnt, adma_gnt, bus_we;
  logic [15:0] bus_addr;
  logic [7:0]  bus_dout;
  logic [1:0]  owner;

  always #5 clk = ~clk;

  sv_bus_arbiter #(.MAX_BURST(MAXB), .GUARD_CYCLES(GC)) dut (
    .clk(clk), .reset(reset), .bus_ce(bus_ce),
    .cpu_addr(cpu_addr), .cpu_dout(cpu_dout), .cpu_we(cpu_we), .cpu_rdy(cpu_rdy),
    .vdma_req(vdma_req), .vdma_addr(vdma_addr), .vdma_dout(vdma_dout), .vdma_we(vdma_we),
    .vdma_gnt(vdma_gnt), .lcd_busy(lcd_busy),
    .adma_req(adma_req), .adma_addr(adma_addr), .adma_gnt(adma_gnt),
    .bus_addr(bus_addr), .bus_dout(bus_dout), .bus_we(bus_we), .owner(owner)
  );

  int n_chk = 0, n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Reference model: owner plus counts of served burst / guard cycles; m_last is the owner code of the last DMA served
  int m_own, m_used, m_guard, m_last;

  task automatic model_reset();
    m_own = 0; m_used = 0; m_guard = 0; m_last = 1;
  endtask

  function automatic int m_arb();
    if (cpu_we) return 0;
    if (adma_req && vdma_req) begin
`ifdef SV_ARB_RR_EN
      return (m_last == 2) ? 1 : 2;
`else
      return 2;
`endif
    end
    if (adma_req) return 2;
    if (vdma_req) return 1;
    return 0;
  endfunction

  task automatic model_step();
    bit req;
    if (!bus_ce) return;
    case (m_own)
      0: begin m_own = m_arb(); m_used = 0; end
      1, 2: begin
        req = (m_own == 1) ? vdma_req : adma_req;
        if (!req) begin
          m_last = m_own;
          if (m_own == 1 && adma_req)      m_own = 2;
          else if (m_own == 2 && vdma_req) m_own = 1;
          else                             m_own = 0;
          m_used = 0;
        end else if (!(m_own == 1 && lcd_busy)) begin
          m_used++;
          if (m_used == MAXB) begin m_last = m_own; m_own = 3; m_guard = 0; m_used = 0; end
        end
      end
      default: begin
        m_guard++;
        if (m_guard == GC) begin m_own = m_arb(); m_used = 0; end
      end
    endcase
  endtask

  task automatic check_model(input string tag);
    logic [15:0] ea;
    logic [7:0]  ed;
    logic        ew;
    ea = (m_own == 1) ? vdma_addr : (m_own == 2) ? adma_addr : cpu_addr;
    ed = (m_own == 1) ? vdma_dout : (m_own == 2) ? 8'h00 : cpu_dout;
    ew = (m_own == 1) ? (vdma_we & ~lcd_busy) : (m_own == 2) ? 1'b0 : cpu_we;
    chk({tag, "_owner"}, owner, m_own);
    chk({tag, "_rdy"}, cpu_rdy, (m_own == 0 || m_own == 3));
    chk({tag, "_vgnt"}, vdma_gnt, (m_own == 1 && !lcd_busy));
    chk({tag, "_agnt"}, adma_gnt, (m_own == 2));
    chk({tag, "_addr"}, bus_addr, ea);
    chk({tag, "_dout"}, bus_dout, ed);
    chk({tag, "_we"}, bus_we, ew);
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic do_reset();
    #2 reset = 1'b1;
    model_reset();
    @(negedge clk) reset = 1'b0;
  endtask

  typedef struct {
    bit ce, we, vr, ar, lb;
    int own;
    bit rdy, vg, ag;
    logic [15:0] addr;
    bit bwe;
  } vec_t;
  vec_t tbl[12];

  task automatic burst_test(input bit stall, input string tag);
    int n1, ng, n3, nst;
    bit done;
    n1 = 0; ng = 0; n3 = 0; nst = 0; done = 0;
    do_reset();
    cpu_we = 0; adma_req = 0; vdma_req = 1; lcd_busy = 0;
    for (int k = 0; k < 80 && !done; k++) begin
      lcd_busy = (stall && m_own == 1 && n1 >= 3 && nst < 5);
      if (lcd_busy) nst++;
      bus_ce = 0;
      tick();
      if (lcd_busy) chk({tag, "_stall_we"}, bus_we, 0);
      if (owner == 2'd3) begin
        n3++;
        chk({tag, "_guard_rdy"}, cpu_rdy, 1);
      end else if (owner == 2'd1) begin
        if (n3 > 0) done = 1;
        else begin n1++; if (vdma_gnt) ng++; end
      end
      bus_ce = 1;
      tick();
      bus_ce = 0;
    end
    lcd_busy = 0;
    chk({tag, "_regrant"}, done, 1);
    chk({tag, "_granted"}, ng, MAXB);
    chk({tag, "_owned"}, n1, MAXB + (stall ? 5 : 0));
    chk({tag, "_guard_len"}, n3, GC);
    vdma_req = 0;
  endtask

  initial begin
    model_reset();
    vdma_req = 1;
    #2;
    chk("reset_owner", owner, 0);
    chk("reset_rdy", cpu_rdy, 1);
    chk("reset_vgnt", vdma_gnt, 0);
    chk("reset_agnt", adma_gnt, 0);
    @(negedge clk) reset = 1'b0;

    //          ce we vr ar lb own rdy vg ag addr      bwe
    tbl[0]  = '{0, 0, 1, 0, 0, 0, 1, 0, 0, 16'h1234, 0};
    tbl[1]  = '{1, 0, 1, 0, 0, 1, 0, 1, 0, 16'h8000, 1};
    tbl[2]  = '{0, 0, 1, 0, 1, 1, 0, 0, 0, 16'h8000, 0};
    tbl[3]  = '{1, 0, 0, 0, 0, 0, 1, 0, 0, 16'h1234, 0};
    tbl[4]  = '{1, 1, 1, 0, 0, 0, 1, 0, 0, 16'h1234, 1};
    tbl[5]  = '{1, 0, 1, 0, 0, 1, 0, 1, 0, 16'h8000, 1};
    tbl[6]  = '{1, 0, 1, 1, 0, 1, 0, 1, 0, 16'h8000, 1};
    tbl[7]  = '{1, 0, 0, 1, 0, 2, 0, 0, 1, 16'hC000, 0};
    tbl[8]  = '{1, 0, 0, 0, 0, 0, 1, 0, 0, 16'h1234, 0};
`ifdef SV_ARB_RR_EN
    tbl[9]  = '{1, 0, 1, 1, 0, 1, 0, 1, 0, 16'h8000, 1};
`else
    tbl[9]  = '{1, 0, 1, 1, 0, 2, 0, 0, 1, 16'hC000, 0};
`endif
    tbl[10] = '{1, 0, 1, 0, 0, 1, 0, 1, 0, 16'h8000, 1};
    tbl[11] = '{1, 0, 0, 0, 0, 0, 1, 0, 0, 16'h1234, 0};

    for (int i = 0; i < 12; i++) begin
      bus_ce = tbl[i].ce; cpu_we = tbl[i].we; vdma_req = tbl[i].vr;
      adma_req = tbl[i].ar; lcd_busy = tbl[i].lb;
      tick();
      chk($sformatf("tbl%0d_owner", i), owner, tbl[i].own);
      chk($sformatf("tbl%0d_rdy", i), cpu_rdy, tbl[i].rdy);
      chk($sformatf("tbl%0d_vgnt", i), vdma_gnt, tbl[i].vg);
      chk($sformatf("tbl%0d_agnt", i), adma_gnt, tbl[i].ag);
      chk($sformatf("tbl%0d_addr", i), bus_addr, tbl[i].addr);
      chk($sformatf("tbl%0d_we", i), bus_we, tbl[i].bwe);
    end
    bus_ce = 0; cpu_we = 0; vdma_req = 0; adma_req = 0; lcd_busy = 0;

    burst_test(0, "burst");
    burst_test(1, "stall");

    // Asynchronous reset in the middle of an audio burst
    do_reset();
    cpu_we = 0; adma_req = 1;
    bus_ce = 1; tick(); bus_ce = 0;
    chk("adma_owner", owner, 2);
    tick(); bus_ce = 1; tick(); bus_ce = 0; tick();
    #3 reset = 1'b1;
    #1;
    model_reset();
    chk("arst_owner", owner, 0);
    chk("arst_rdy", cpu_rdy, 1);
    chk("arst_agnt", adma_gnt, 0);
    @(negedge clk) reset = 1'b0;
    bus_ce = 1; tick(); bus_ce = 0;
    chk("arst_regrant_owner", owner, 2);
    chk("arst_regrant_agnt", adma_gnt, 1);
    adma_req = 0;

    do_reset();
    for (int i = 0; i < 3000; i++) begin
      bus_ce    = ($urandom_range(2) == 0);
      cpu_we    = ($urandom_range(3) == 0);
      lcd_busy  = ($urandom_range(3) == 0);
      vdma_we   = $urandom_range(1);
      if ($urandom_range(7) == 0) vdma_req = ~vdma_req;
      if ($urandom_range(11) == 0) adma_req = ~adma_req;
      cpu_addr  = 16'($urandom); vdma_addr = 16'($urandom); adma_addr = 16'($urandom);
      cpu_dout  = 8'($urandom);  vdma_dout = 8'($urandom);
      tick();
      check_model("rnd");
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
